serial_subtractor_ctrl: RTL and testbench
=========================================

# serial_subtractor_ctrl

Bit-serial subtraction controller. It accepts two WIDTH-bit operands and a borrow-in, then drives a single 1-bit full-subtractor stage once per clock from LSB to MSB, holding the running borrow in a flop. When all bits are processed it presents the difference, the borrow-out and a signed-overflow flag. It sits in the arithmetic section as the sequencer that lets one full-subtractor cell perform multi-bit subtraction.

## Interface
- WIDTH, 8, operand and result width in bits (legal range 1..32)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on the accepting edge
- b  input  WIDTH  subtrahend, captured on the accepting edge
- b_in  input  1  initial borrow, captured on the accepting edge
- busy  output  1  high in RUN and DONE
- done  output  1  single-cycle completion pulse
- diff  output  WIDTH  result a - b - b_in, modulo 2^WIDTH
- borrow_out  output  1  borrow out of the MSB (unsigned underflow)
- overflow  output  1  signed two's-complement overflow

## Operation
- One clock domain. Reset is asynchronous and active-low.
- Reset values: state IDLE; busy, done, diff, borrow_out and overflow are all 0; internal shift registers, borrow flop and bit counter are cleared.
- Per-bit cell function, with x = current LSB of the a-shift register, y = current LSB of the b-shift register, bw = borrow flop:
  - d = x ^ y ^ bw
  - bw_next = (~x & y) | (~(x ^ y) & bw)
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - When start=1, capture a and b into the shift registers and b_in into the borrow flop, clear the counter, and go to RUN.
  - When start=0, stay in IDLE.
- RUN, on each edge:
  - Shift d into the MSB of the result shift register and shift both operand registers right by one.
  - Load bw_next into the borrow flop and increment the counter.
  - When the counter equals WIDTH-1 (the last bit is being processed), go to DONE.
  - On that same last edge, latch msb_bin = bw (the borrow into the MSB stage).
- Leaving RUN for DONE:
  - Load diff from the completed shift register and borrow_out from bw_next.
  - Set overflow = msb_bin ^ bw_next.
  - done is registered high for exactly one cycle.
- DONE: go to IDLE on the next edge and drop done.
- Output stability: diff, borrow_out and overflow change only on the RUN-to-DONE transition. They hold their values through IDLE and the whole next operation until that operation completes.
- start while busy (RUN or DONE): ignored and not queued.
- Reset mid-operation: the operation is abandoned, every output returns to 0, and no done pulse is produced.
- WIDTH=1: RUN lasts exactly one edge, and overflow = b_in ^ borrow_out.

## Timing
- Edge E0 accepts start (state is IDLE and start=1).
- Edges E1..E_WIDTH are the RUN edges, one bit each, LSB first.
- done is high in the cycle after E_WIDTH, and the results are valid from that edge onward.
- Latency from the accepting edge to done is WIDTH cycles.
- E_WIDTH+1 returns the FSM to IDLE. The earliest next accept is E_WIDTH+2, so a held-high start gives one operation every WIDTH+2 cycles.
- busy rises after E0 and falls after E_WIDTH+1.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, b_in=0 -> diff=0x1E, borrow_out=0, overflow=0; done pulses once, 8 cycles after acceptance.
- WIDTH=8, a=0x00, b=0x01, b_in=0 -> diff=0xFF, borrow_out=1, overflow=0. Then a=0x10, b=0x0F, b_in=1 -> diff=0x00, borrow_out=0, overflow=0.
- WIDTH=8, a=0x80, b=0x01, b_in=0 -> diff=0x7F, borrow_out=0, overflow=1. Then a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
- start held high for 30 cycles with the operands changed every cycle -> accepts every 10 cycles. Each result matches the operands present on its accepting edge, pulses of start during busy are ignored, and diff is stable between done pulses.
- Assert rst_n=0 at RUN cycle 4 of a=0xFF, b=0x01 -> all outputs 0 immediately and no done pulse. After release, a=0x03, b=0x05 -> diff=0xFE, borrow_out=1.
- WIDTH=1, sweep all 8 combinations of a, b, b_in -> done one cycle after acceptance; diff, borrow_out and overflow match the cell equations.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial subtraction sequencer.
// A single full-subtractor cell is stepped LSB-first over WIDTH clocks. A
// borrow flop carries between bits. On the last bit the difference, the
// borrow-out and the signed-overflow flag are published, along with a
// one-cycle done pulse.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nxt;
  logic [CW-1:0]    cnt;
  logic             bw, bw_nxt, d, last;

  // Full-subtractor cell: returns {borrow_next, difference_bit}.
  function automatic logic [1:0] sub_cell(input logic x, input logic y, input logic bi);
    sub_cell = {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
  endfunction

  // Cell evaluation on the current LSBs and the result register with the new bit shifted in.
  always_comb begin
    {bw_nxt, d}      = sub_cell(a_sh[0], b_sh[0], bw);
    r_nxt            = r_sh >> 1;
    r_nxt[WIDTH-1]   = d;
    last             = (cnt == LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start is only looked at in IDLE, so it is never queued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Operand capture, bit-serial stepping and publication of the results.
  // The borrow entering the MSB is the current bw on the last edge, so the
  // overflow flag is formed directly from bw and bw_nxt on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      bw         <= 1'b0;
      cnt        <= '0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= (state == RUN) && last;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            bw   <= b_in;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_nxt;
          bw   <= bw_nxt;
          cnt  <= cnt + CW'(1);
          if (last) begin
            diff       <= r_nxt;
            borrow_out <= bw_nxt;
            overflow   <= bw ^ bw_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Testbench for serial_subtractor_ctrl: a WIDTH=8 and a WIDTH=1 instance share clock and reset.
module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s8, bi8, busy8, done8, bo8, ov8;
  logic [7:0] a8, b8, diff8;
  logic       s1, a1, b1, bi1, busy1, done1, diff1, bo1, ov1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .b_in(bi8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .overflow(ov8)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .b_in(bi1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1), .overflow(ov1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values, returns {ov, bo, diff}.
  function automatic logic [9:0] model(input int w, input int unsigned a, input int unsigned b,
                                       input int unsigned bin);
    longint m, r, d, sa, sb, sr;
    logic bo, ov;
    m  = longint'(1) << w;
    r  = longint'(a) - longint'(b) - longint'(bin);
    d  = ((r % m) + m) % m;
    bo = (r < 0);
    sa = (longint'(a) >= m / 2) ? longint'(a) - m : longint'(a);
    sb = (longint'(b) >= m / 2) ? longint'(b) - m : longint'(b);
    sr = sa - sb - longint'(bin);
    ov = (sr < -(m / 2)) || (sr > (m / 2) - 1);
    model = {ov, bo, d[7:0]};
  endfunction

  function automatic logic cur_done(input bit w1);
    cur_done = w1 ? done1 : done8;
  endfunction

  // One full operation: accept, measure latency to done, check results and the single pulse.
  task automatic run_op(input bit w1, input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic eb, input logic eo, input string nm);
    int lat;
    lat = 0;
    @(negedge clk);
    if (w1) begin s1 = 1'b1; a1 = a[0]; b1 = b[0]; bi1 = bin; end
    else    begin s8 = 1'b1; a8 = a;    b8 = b;    bi8 = bin; end
    @(posedge clk);
    @(negedge clk);
    s1 = 1'b0; s8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
    a1 = 1'($urandom); b1 = 1'($urandom); bi1 = 1'($urandom);
    if (cur_done(w1)) lat = 0;
    else begin
      for (int n = 1; n <= 20; n++) begin
        @(posedge clk);
        @(negedge clk);
        if (cur_done(w1)) begin lat = n; break; end
      end
    end
    check({nm, "_latency"}, lat, w1 ? 1 : 8);
    if (w1) begin
      check({nm, "_diff"}, {31'b0, diff1}, {31'b0, ed[0]});
      check({nm, "_borrow"}, {31'b0, bo1}, {31'b0, eb});
      check({nm, "_ovf"}, {31'b0, ov1}, {31'b0, eo});
      check({nm, "_busy_done"}, {31'b0, busy1}, 1);
    end else begin
      check({nm, "_diff"}, {24'b0, diff8}, {24'b0, ed});
      check({nm, "_borrow"}, {31'b0, bo8}, {31'b0, eb});
      check({nm, "_ovf"}, {31'b0, ov8}, {31'b0, eo});
      check({nm, "_busy_done"}, {31'b0, busy8}, 1);
    end
    @(posedge clk);
    @(negedge clk);
    check({nm, "_done_drop"}, {31'b0, cur_done(w1)}, 0);
    check({nm, "_idle"}, {31'b0, (w1 ? busy1 : busy8)}, 0);
  endtask

  initial begin
    logic [9:0] e;
    logic [9:0] q[$];
    logic [7:0] last_diff;
    logic [7:0] ra, rb;
    logic       rbi;
    int         idle_in, pulses;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

    s8 = 0; a8 = 0; b8 = 0; bi8 = 0;
    s1 = 0; a1 = 0; b1 = 0; bi1 = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy8}, 0);
    check("rst_done", {31'b0, done8}, 0);
    check("rst_diff", {24'b0, diff8}, 0);
    check("rst_borrow", {31'b0, bo8}, 0);
    check("rst_ovf", {31'b0, ov8}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 5; i++)
      run_op(1'b0, tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bo, tbl[i].ov,
             $sformatf("tbl%0d", i));

    // Reset in RUN cycle 4: outputs clear at once and no done pulse follows.
    @(negedge clk);
    s8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; bi8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy8}, 0);
    check("midrst_done", {31'b0, done8}, 0);
    check("midrst_diff", {24'b0, diff8}, 0);
    check("midrst_borrow", {31'b0, bo8}, 0);
    check("midrst_ovf", {31'b0, ov8}, 0);
    pulses = 0;
    repeat (2) begin @(negedge clk); if (done8) pulses++; end
    rst_n = 1'b1;
    repeat (12) begin @(negedge clk); if (done8 || busy8) pulses++; end
    check("midrst_no_done", pulses, 0);
    run_op(1'b0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, "after_rst");

    // start held high with operands changing every cycle
    last_diff = 8'hFE;
    idle_in = 0;
    pulses = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 45; cyc++) begin
      s8  = (cyc < 30);
      ra  = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      a8  = ra; b8 = rb; bi8 = rbi;
      @(posedge clk);
      if (idle_in == 0 && s8) begin
        q.push_back(model(8, ra, rb, rbi));
        idle_in = 9;
      end else if (idle_in > 0) idle_in--;
      @(negedge clk);
      if (done8) begin
        pulses++;
        if (q.size() == 0) check("held_unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          check($sformatf("held%0d_diff", cyc), {24'b0, diff8}, {24'b0, e[7:0]});
          check($sformatf("held%0d_borrow", cyc), {31'b0, bo8}, {31'b0, e[8]});
          check($sformatf("held%0d_ovf", cyc), {31'b0, ov8}, {31'b0, e[9]});
        end
        last_diff = diff8;
      end else begin
        check($sformatf("held%0d_stable", cyc), {24'b0, diff8}, {24'b0, last_diff});
      end
    end
    s8 = 1'b0;
    check("held_pulses", pulses, 3);
    check("held_drained", q.size(), 0);

    // Random operations against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      if (i == 0) begin ra = 8'h00; rb = 8'hFF; rbi = 1'b1; end
      e = model(8, ra, rb, rbi);
      run_op(1'b0, ra, rb, rbi, e[7:0], e[8], e[9], $sformatf("rnd%0d", i));
    end

    // WIDTH=1 exhaustive sweep
    for (int i = 0; i < 8; i++) begin
      ra  = {7'b0, 1'(i >> 2)};
      rb  = {7'b0, 1'(i >> 1)};
      rbi = 1'(i);
      e = model(1, ra, rb, rbi);
      run_op(1'b1, ra, rb, rbi, e[7:0], e[8], e[9], $sformatf("w1_%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
